bus_driver_n: RTL and testbench

Parametrised, registered memory-mapped bus controller between the RV32 core's load/store port and its N peripheral slots. It decodes each access against a per-slot base/mask map and issues a one-cycle write or read strobe to the selected slot. It inserts per-slot wait states and returns registered read data with a ready handshake. Unmapped accesses are flagged with a sticky error and a captured address.

---
 rtl/bus_map_pkg.sv | 43 ++++
 rtl/bus_addr_match.sv | 28 ++
 rtl/bus_driver_n.sv | 165 ++++++++++++++++
 tb/tb_bus_driver_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// Shared definitions for the bus controller.
// Contents: the per-slot configuration record, the default slot map, the slot
// index names, and the controller state type.
package bus_map_pkg;

    localparam int MAP_SLOTS = 8;

    // 'wait' is a SystemVerilog keyword, so the wait-state field is named 'waits'.
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic [3:0]  waits;
    } slot_cfg_t;

    localparam int SLOT_RAM       = 0;
    localparam int SLOT_KEYBOARD  = 1;
    localparam int SLOT_LEDS      = 2;
    localparam int SLOT_SEVEN_SEG = 3;
    localparam int SLOT_TIMER     = 4;
    localparam int SLOT_UART_CTRL = 5;
    localparam int SLOT_UART_DATA = 6;
    localparam int SLOT_SPI_CTRL  = 7;

    // Single-register peripherals use an all-ones mask, so they decode one exact word.
    localparam slot_cfg_t SLOT_MAP [MAP_SLOTS] = '{
        '{base: 32'h0000_1000, mask: 32'hFFFF_F000, waits: 4'd1},
        '{base: 32'h0000_2000, mask: 32'hFFFF_FFFF, waits: 4'd0},
        '{base: 32'h0000_2008, mask: 32'hFFFF_FFFF, waits: 4'd0},
        '{base: 32'h0000_200C, mask: 32'hFFFF_FFFF, waits: 4'd0},
        '{base: 32'h0000_2010, mask: 32'hFFFF_FFFF, waits: 4'd0},
        '{base: 32'h0000_2020, mask: 32'hFFFF_FFFF, waits: 4'd0},
        '{base: 32'h0000_2024, mask: 32'hFFFF_FFFF, waits: 4'd2},
        '{base: 32'h0000_2100, mask: 32'hFFFF_FFFF, waits: 4'd0}
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/bus_addr_match.sv
// Combinational priority address decoder.
// Ports: address_i (access address) -> hit_o (some slot matches),
//        idx_o (index of the lowest-numbered matching slot).
module bus_addr_match
    import bus_map_pkg::*;
#(
    parameter int N_SLOTS = 8,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 3
) (
    input  logic [ADDR_W-1:0] address_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Scanning from the top down lets the lowest-index match overwrite the others.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if ((address_i & SLOT_MAP[i].mask[ADDR_W-1:0]) == SLOT_MAP[i].base[ADDR_W-1:0]) begin
                hit_o = 1'b1;
                idx_o = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_driver_n.sv
// Registered memory-mapped bus controller between the core load/store port
// and N peripheral slots.
// Ports: clk_i/rst_i (sync active-high reset); core side address_i, we_i, re_i,
//        wdata_i, rdata_o, ready_o; slot side wdata_o, we_o, re_o (one-hot),
//        rdata_slots_i (slot i at bits [i*DATA_W +: DATA_W]); error side
//        err_o, err_flag_o, err_addr_o, err_clr_i.
//
// state  | meaning
// IDLE   | waiting for a request; decodes and latches it
// ACCESS | one-cycle strobe to the selected slot, wait counter loaded
// WAIT   | counting down the slot's wait states
// RESP   | ready_o pulse (with err_o on a miss), then back to IDLE
module bus_driver_n
    import bus_map_pkg::*;
#(
    parameter int N_SLOTS = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WAIT_W  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         address_i,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         wdata_o,
    output logic [N_SLOTS-1:0]        we_o,
    output logic [N_SLOTS-1:0]        re_o,
    input  logic [N_SLOTS*DATA_W-1:0] rdata_slots_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      ready_o,
    output logic                      err_o,
    output logic                      err_flag_o,
    output logic [ADDR_W-1:0]         err_addr_o,
    input  logic                      err_clr_i
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    state_t              state_q;
    logic [IDX_W-1:0]    slot_q;
    logic                op_we_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [N_SLOTS-1:0]  we_q;
    logic [N_SLOTS-1:0]  re_q;
    logic                ready_q;
    logic                err_q;
    logic                err_flag_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [N_SLOTS-1:0]  strobe_d;
    logic [WAIT_W-1:0]   slot_waits_d;
    logic [DATA_W-1:0]   slot_rdata_d;

    bus_addr_match #(
        .N_SLOTS (N_SLOTS),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .address_i (address_i),
        .hit_o     (hit),
        .idx_o     (hit_idx)
    );

    assign strobe_d     = {{(N_SLOTS-1){1'b0}}, 1'b1} << hit_idx;
    assign slot_waits_d = SLOT_MAP[slot_q].waits[WAIT_W-1:0];
    assign slot_rdata_d = rdata_slots_i[int'(slot_q)*DATA_W +: DATA_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            op_we_q    <= 1'b0;
            wait_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= '0;
            re_q       <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // Strobes and the ready/err pulses last exactly one cycle.
            we_q    <= '0;
            re_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            // A miss taken in IDLE below overrides this, so a set beats a clear.
            if (err_clr_i) begin
                err_flag_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (we_i || re_i) begin
                        slot_q  <= hit_idx;
                        op_we_q <= we_i;
                        wdata_q <= wdata_i;
                        if (hit) begin
                            // A write takes priority when both requests are high.
                            if (we_i) begin
                                we_q <= strobe_d;
                            end else begin
                                re_q <= strobe_d;
                            end
                            state_q <= ST_ACCESS;
                        end else begin
                            ready_q    <= 1'b1;
                            err_q      <= 1'b1;
                            err_flag_q <= 1'b1;
                            err_addr_q <= address_i;
                            rdata_q    <= '0;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    wait_q <= slot_waits_d;
                    if (slot_waits_d == '0) begin
                        ready_q <= 1'b1;
                        if (!op_we_q) begin
                            rdata_q <= slot_rdata_d;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q - 1'b1;
                    if (wait_q == WAIT_W'(1)) begin
                        ready_q <= 1'b1;
                        if (!op_we_q) begin
                            rdata_q <= slot_rdata_d;
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wdata_o    = wdata_q;
    assign we_o       = we_q;
    assign re_o       = re_q;
    assign rdata_o    = rdata_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign err_flag_o = err_flag_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bus_driver_n.sv
module tb_bus_driver_n;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  address_i;
    logic         we_i;
    logic         re_i;
    logic [31:0]  wdata_i;
    logic [31:0]  wdata_o;
    logic [7:0]   we_o;
    logic [7:0]   re_o;
    logic [255:0] rdata_slots_i;
    logic [31:0]  rdata_o;
    logic         ready_o;
    logic         err_o;
    logic         err_flag_o;
    logic [31:0]  err_addr_o;
    logic         err_clr_i;

    int checks = 0;
    int errors = 0;

    bus_driver_n #(
        .N_SLOTS (8),
        .ADDR_W  (32),
        .DATA_W  (32),
        .WAIT_W  (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .address_i     (address_i),
        .we_i          (we_i),
        .re_i          (re_i),
        .wdata_i       (wdata_i),
        .wdata_o       (wdata_o),
        .we_o          (we_o),
        .re_o          (re_o),
        .rdata_slots_i (rdata_slots_i),
        .rdata_o       (rdata_o),
        .ready_o       (ready_o),
        .err_o         (err_o),
        .err_flag_o    (err_flag_o),
        .err_addr_o    (err_addr_o),
        .err_clr_i     (err_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic [7:0]  exp_we;
        logic [7:0]  exp_re;
        int          exp_rdy;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] slot_data [8];
    logic [31:0] map_addr  [8];
    int          map_rdy   [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] addr, input logic we,
                                input logic re, input logic [31:0] wdata, input logic [7:0] exp_we,
                                input logic [7:0] exp_re, input int exp_rdy, input logic exp_err,
                                input logic chk_rd, input logic [31:0] exp_rd);
        vec_t v;
        v.name = name; v.addr = addr; v.we = we; v.re = re; v.wdata = wdata;
        v.exp_we = exp_we; v.exp_re = exp_re; v.exp_rdy = exp_rdy; v.exp_err = exp_err;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Called just after a clock edge with the FSM about to be in IDLE. Returns with
    // the request dropped, just after the edge that leaves RESP.
    task automatic run_vec(input vec_t v);
        int rdy_cyc = 0;
        int extra   = 0;
        address_i = v.addr;
        we_i      = v.we;
        re_i      = v.re;
        wdata_i   = v.wdata;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_i); #1;
            if (c == 1) begin
                check({v.name, " we_o c1"}, 64'(we_o), 64'(v.exp_we));
                check({v.name, " re_o c1"}, 64'(re_o), 64'(v.exp_re));
            end else if (we_o != 0 || re_o != 0) begin
                extra++;
            end
            if (ready_o) begin
                rdy_cyc = c;
                check({v.name, " err_o"}, 64'(err_o), 64'(v.exp_err));
                check({v.name, " wdata_o"}, 64'(wdata_o), 64'(v.wdata));
                if (v.chk_rd) check({v.name, " rdata_o"}, 64'(rdata_o), 64'(v.exp_rd));
                if (v.exp_err) begin
                    check({v.name, " err_addr_o"}, 64'(err_addr_o), 64'(v.addr));
                    check({v.name, " err_flag_o"}, 64'(err_flag_o), 64'd1);
                end
                break;
            end
        end
        check({v.name, " ready cycle"}, 64'(rdy_cyc), 64'(v.exp_rdy));
        check({v.name, " extra strobes"}, 64'(extra), 64'd0);
        @(posedge clk_i); #1;
        check({v.name, " ready one cycle"}, 64'(ready_o), 64'd0);
        we_i = 1'b0;
        re_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        address_i = '0;
        we_i      = 1'b0;
        re_i      = 1'b0;
        wdata_i   = '0;
        err_clr_i = 1'b0;

        slot_data[0] = 32'h1234_5678;
        for (int i = 1; i < 8; i++) slot_data[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
        for (int i = 0; i < 8; i++) rdata_slots_i[i*32 +: 32] = slot_data[i];

        map_addr = '{32'h1000, 32'h2000, 32'h2008, 32'h200C, 32'h2010, 32'h2020, 32'h2024, 32'h2100};
        map_rdy  = '{3, 2, 2, 2, 2, 2, 4, 2};

        vecs.push_back(mk("wr_leds", 32'h2008, 1, 0, 32'hA5, 8'h04, 8'h00, 2, 0, 0, 0));
        vecs.push_back(mk("rd_ram", 32'h1004, 0, 1, 32'h0, 8'h00, 8'h01, 3, 0, 1, 32'h1234_5678));
        vecs.push_back(mk("rd_uart_data", 32'h2024, 0, 1, 32'h0, 8'h00, 8'h40, 4, 0, 1, slot_data[6]));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("sweep_rd%0d", i), map_addr[i], 0, 1, 32'h0,
                              8'h00, 8'(1) << i, map_rdy[i], 0, 1, slot_data[i]));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("sweep_wr%0d", i), map_addr[i], 1, 0, 32'h100 + 32'(i),
                              8'(1) << i, 8'h00, map_rdy[i], 0, 1, slot_data[7]));
        vecs.push_back(mk("wr_and_rd_timer", 32'h2010, 1, 1, 32'h77, 8'h10, 8'h00, 2, 0, 1, slot_data[7]));
        vecs.push_back(mk("ram_top", 32'h1FFC, 0, 1, 32'h0, 8'h00, 8'h01, 3, 0, 1, slot_data[0]));
        vecs.push_back(mk("miss_wr_0", 32'h0000, 1, 0, 32'h5A, 8'h00, 8'h00, 1, 1, 1, 32'h0));
        vecs.push_back(mk("rd_kbd", 32'h2000, 0, 1, 32'h0, 8'h00, 8'h02, 2, 0, 1, slot_data[1]));
        vecs.push_back(mk("miss_rd_2001", 32'h2001, 0, 1, 32'h0, 8'h00, 8'h00, 1, 1, 1, 32'h0));

        repeat (3) @(posedge clk_i);
        #1;
        check("reset we_o", 64'(we_o), 64'd0);
        check("reset re_o", 64'(re_o), 64'd0);
        check("reset ready_o", 64'(ready_o), 64'd0);
        check("reset err_o", 64'(err_o), 64'd0);
        check("reset err_flag_o", 64'(err_flag_o), 64'd0);
        check("reset rdata_o", 64'(rdata_o), 64'd0);
        check("reset wdata_o", 64'(wdata_o), 64'd0);
        check("reset err_addr_o", 64'(err_addr_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Sticky flag survives idle cycles, then clears on err_clr_i.
        @(posedge clk_i); #1;
        check("flag sticky", 64'(err_flag_o), 64'd1);
        check("err_addr last miss", 64'(err_addr_o), 64'h2001);
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        check("flag cleared", 64'(err_flag_o), 64'd0);

        // New miss together with err_clr_i: set wins.
        address_i = 32'h0000_0004;
        re_i      = 1'b1;
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        check("set beats clear flag", 64'(err_flag_o), 64'd1);
        check("set beats clear ready", 64'(ready_o), 64'd1);
        check("set beats clear addr", 64'(err_addr_o), 64'h4);
        @(posedge clk_i); #1;
        re_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset during WAIT of a RAM read.
        address_i = 32'h1000;
        re_i      = 1'b1;
        @(posedge clk_i); #1;
        check("rst seq strobe", 64'(re_o), 64'h01);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        re_i  = 1'b0;
        check("rst mid ready_o", 64'(ready_o), 64'd0);
        check("rst mid strobes", 64'({we_o, re_o}), 64'd0);
        check("rst mid rdata_o", 64'(rdata_o), 64'd0);
        check("rst mid err_flag_o", 64'(err_flag_o), 64'd0);
        check("rst mid err_addr_o", 64'(err_addr_o), 64'd0);
        check("rst mid wdata_o", 64'(wdata_o), 64'd0);
        @(posedge clk_i); #1;
        check("rst after ready_o", 64'(ready_o), 64'd0);
        run_vec(mk("after_rst_rd", 32'h1004, 0, 1, 32'h0, 8'h00, 8'h01, 3, 0, 1, slot_data[0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
